hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_sat_counter.sv | 18 +
 rtl/hazard_ctrl.sv | 99 +++++++++
 tb/tb_hazard_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM state codes and
// write-back select values.
package hazard_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LSTALL = 2'd1;
  localparam logic [1:0] ST_MC     = 2'd2;

  localparam logic [2:0] WDSEL_ALU = 3'b000;
  localparam logic [2:0] WDSEL_MEM = 3'b001;
  localparam logic [2:0] WDSEL_PC4 = 3'b010;
  localparam logic [2:0] WDSEL_CSR = 3'b011;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: counts cycles with inc=1 and sticks at all-ones.
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle EX holds and
// redirect flushes, plus a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int                 REG_AW     = 5,
  parameter int                 WDSEL_W    = 3,
  parameter logic [WDSEL_W-1:0] WDSEL_MEM  = WDSEL_W'(hazard_pkg::WDSEL_MEM),
  parameter int                 LOAD_STALL = 1,
  parameter int                 CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_AW-1:0]  IF_ID_rs1,
  input  logic [REG_AW-1:0]  IF_ID_rs2,
  input  logic [REG_AW-1:0]  ID_EX_rd,
  input  logic [WDSEL_W-1:0] ID_EX_WDSel,
  input  logic               ex_mc_start,
  input  logic               ex_mc_done,
  input  logic               redirect,
  output logic               is_stall,
  output logic               IF_ID_write_enable,
  output logic               ID_EX_flush,
  output logic               IF_ID_flush,
  output logic               ID_EX_hold,
  output logic               mc_kill,
  output logic [CNT_W-1:0]   stall_cnt
);

  import hazard_pkg::*;

  // The detect cycle is the first bubble; LSTALL supplies the remaining ones.
  localparam logic [1:0] LCNT_INIT = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;

  logic [1:0] state, state_nxt, st;
  logic [1:0] lcnt, lcnt_nxt;
  logic       lu;

  assign lu = (ID_EX_rd != '0) &&
              ((IF_ID_rs1 == ID_EX_rd) || (IF_ID_rs2 == ID_EX_rd)) &&
              (ID_EX_WDSel == WDSEL_MEM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      lcnt  <= '0;
    end else begin
      state <= state_nxt;
      lcnt  <= lcnt_nxt;
    end
  end

  always_comb begin
    // Under reset the decode sees IDLE so no stale stall leaks out.
    st                 = rst ? ST_IDLE : state;
    state_nxt          = ST_IDLE;
    lcnt_nxt           = '0;
    is_stall           = 1'b0;
    IF_ID_write_enable = 1'b1;
    ID_EX_flush        = 1'b0;
    IF_ID_flush        = 1'b0;
    ID_EX_hold         = 1'b0;
    mc_kill            = 1'b0;
    if (redirect) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      mc_kill     = !rst && ((st == ST_MC) || ex_mc_start);
    end else if ((st == ST_MC) || ex_mc_start) begin
      if (!ex_mc_done) begin
        is_stall           = 1'b1;
        IF_ID_write_enable = 1'b0;
        ID_EX_hold         = 1'b1;
        state_nxt          = ST_MC;
      end
    end else if (st == ST_LSTALL) begin
      is_stall           = 1'b1;
      IF_ID_write_enable = 1'b0;
      ID_EX_flush        = 1'b1;
      if (lcnt != 2'd0) begin
        state_nxt = ST_LSTALL;
        lcnt_nxt  = lcnt - 2'd1;
      end
    end else if (lu) begin
      is_stall           = 1'b1;
      IF_ID_write_enable = 1'b0;
      ID_EX_flush        = 1'b1;
      if (LOAD_STALL > 1) begin
        state_nxt = ST_LSTALL;
        lcnt_nxt  = LCNT_INIT;
      end
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (is_stall),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (LOAD_STALL 1/3/4) share
// stimulus; each step's expected outputs go through a scoreboard queue.
module tb_hazard_ctrl;

  localparam logic [5:0] E_IDLE = 6'b010000;
  localparam logic [5:0] E_LU   = 6'b101000;
  localparam logic [5:0] E_MC   = 6'b100010;
  localparam logic [5:0] E_RED  = 6'b011100;
  localparam logic [5:0] E_KILL = 6'b011101;

  typedef struct {
    string      tag;
    int         d;
    logic [5:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] wdsel;
  logic start, done, redir;
  wire  [5:0] o1, o3, o4;
  wire  [31:0] c1, c3;
  wire  [1:0] c4;
  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL(1)) d1 (
    .clk(clk), .rst(rst), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .ID_EX_rd(rd),
    .ID_EX_WDSel(wdsel), .ex_mc_start(start), .ex_mc_done(done), .redirect(redir),
    .is_stall(o1[5]), .IF_ID_write_enable(o1[4]), .ID_EX_flush(o1[3]),
    .IF_ID_flush(o1[2]), .ID_EX_hold(o1[1]), .mc_kill(o1[0]), .stall_cnt(c1));

  hazard_ctrl #(.LOAD_STALL(3)) d3 (
    .clk(clk), .rst(rst), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .ID_EX_rd(rd),
    .ID_EX_WDSel(wdsel), .ex_mc_start(start), .ex_mc_done(done), .redirect(redir),
    .is_stall(o3[5]), .IF_ID_write_enable(o3[4]), .ID_EX_flush(o3[3]),
    .IF_ID_flush(o3[2]), .ID_EX_hold(o3[1]), .mc_kill(o3[0]), .stall_cnt(c3));

  hazard_ctrl #(.LOAD_STALL(4), .CNT_W(2)) d4 (
    .clk(clk), .rst(rst), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .ID_EX_rd(rd),
    .ID_EX_WDSel(wdsel), .ex_mc_start(start), .ex_mc_done(done), .redirect(redir),
    .is_stall(o4[5]), .IF_ID_write_enable(o4[4]), .ID_EX_flush(o4[3]),
    .IF_ID_flush(o4[2]), .ID_EX_hold(o4[1]), .mc_kill(o4[0]), .stall_cnt(c4));

  function automatic logic [5:0] pick(input int d);
    case (d)
      3:       return o3;
      4:       return o4;
      default: return o1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One cycle: drive after the rising edge, compare outputs at the falling edge.
  task automatic step(input string tag, input int d, input logic [5:0] v,
                      input logic r, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] dst, input logic [2:0] w,
                      input logic s, input logic dn, input logic rd_i);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rs1 = a; rs2 = b; rd = dst; wdsel = w;
    start = s; done = dn; redir = rd_i;
    q.push_back('{tag, d, v});
    @(negedge clk);
    e = q.pop_front();
    n_chk++;
    assert (pick(e.d) === e.v) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", e.tag, pick(e.d), e.v);
  endtask

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; wdsel = '0;
    start = 1'b0; done = 1'b0; redir = 1'b0;

    // reset behaviour: IDLE decode of live inputs, no kill, counter held at 0
    step("rst_idle",        1, E_IDLE, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_cnt", c1, 0);
    step("rst_lu_decode",   1, E_LU,   1, 0, 5, 5, 1, 0, 0, 0);
    step("rst_redir_nokill",1, E_RED,  1, 0, 0, 0, 0, 1, 0, 1);
    step("post_rst_idle",   1, E_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_cnt_held", c1, 0);

    // single-bubble load-use and non-hazard patterns
    step("lu1",             1, E_LU,   0, 0, 5, 5, 1, 0, 0, 0);
    step("lu1_release",     1, E_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu1_cnt", c1, 1);
    step("rd_zero",         1, E_IDLE, 0, 0, 0, 0, 1, 0, 0, 0);
    step("wdsel_alu",       1, E_IDLE, 0, 5, 0, 5, 0, 0, 0, 0);
    step("lu_rs1",          1, E_LU,   0, 7, 0, 7, 1, 0, 0, 0);
    step("lu_rs1_release",  1, E_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_rs1_cnt", c1, 2);

    // multi-cycle op: issue + 3 MC cycles, released in the done cycle
    step("mc_issue",        1, E_MC,   0, 0, 0, 0, 0, 1, 0, 0);
    step("mc_1",            1, E_MC,   0, 0, 0, 0, 0, 0, 0, 0);
    step("mc_2",            1, E_MC,   0, 0, 0, 0, 0, 0, 0, 0);
    step("mc_3",            1, E_MC,   0, 0, 0, 0, 0, 0, 0, 0);
    step("mc_done",         1, E_IDLE, 0, 0, 0, 0, 0, 0, 1, 0);
    step("mc_after",        1, E_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mc_cnt", c1, 6);
    step("mc_single",       1, E_IDLE, 0, 0, 0, 0, 0, 1, 1, 0);
    step("mc_single_after", 1, E_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
    step("mc_over_lu",      1, E_MC,   0, 0, 5, 5, 1, 1, 0, 0);
    step("mc_done_over_lu", 1, E_IDLE, 0, 0, 5, 5, 1, 0, 1, 0);
    step("mc_over_lu_after",1, E_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mc_over_lu_cnt", c1, 7);

    // redirect kills the multi-cycle op and flushes
    step("mc_issue2",       1, E_MC,   0, 0, 0, 0, 0, 1, 0, 0);
    step("mc2_1",           1, E_MC,   0, 0, 0, 0, 0, 0, 0, 0);
    step("mc2_redirect",    1, E_KILL, 0, 0, 0, 0, 0, 0, 0, 1);
    step("mc2_after_redir", 1, E_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
    step("redir_with_start",1, E_KILL, 0, 0, 0, 0, 0, 1, 0, 1);
    step("redir_start_after",1,E_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
    step("redir_over_lu",   1, E_RED,  0, 0, 5, 5, 1, 0, 0, 1);
    chk("redir_cnt", c1, 9);

    // LOAD_STALL=3: exactly three bubbles, lu ignored while in LSTALL
    step("l3_rst",          3, E_IDLE, 1, 0, 0, 0, 0, 0, 0, 0);
    step("l3_0",            3, E_LU,   0, 0, 5, 5, 1, 0, 0, 0);
    step("l3_1",            3, E_LU,   0, 0, 5, 5, 1, 0, 0, 0);
    step("l3_2",            3, E_LU,   0, 0, 0, 0, 0, 0, 0, 0);
    step("l3_end",          3, E_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("l3_cnt", c3, 3);
    step("l3_lu_again",     3, E_LU,   0, 0, 5, 5, 1, 0, 0, 0);
    step("l3_redir_lstall", 3, E_RED,  0, 0, 0, 0, 0, 0, 0, 1);
    step("l3_after_redir",  3, E_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);

    // LOAD_STALL=4: reset mid-LSTALL, then 2-bit counter saturation
    step("l4_rst",          4, E_IDLE, 1, 0, 0, 0, 0, 0, 0, 0);
    step("l4_0",            4, E_LU,   0, 0, 5, 5, 1, 0, 0, 0);
    step("l4_1",            4, E_LU,   0, 0, 0, 0, 0, 0, 0, 0);
    step("l4_mid_rst",      4, E_IDLE, 1, 0, 0, 0, 0, 0, 0, 0);
    step("l4_no_residual",  4, E_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("l4_cnt_reset", {30'd0, c4}, 0);
    step("l4_full_0",       4, E_LU,   0, 0, 5, 5, 1, 0, 0, 0);
    for (int i = 1; i < 4; i++)
      step($sformatf("l4_full_%0d", i), 4, E_LU, 0, 0, 0, 0, 0, 0, 0, 0);
    step("l4_full_end",     4, E_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("l4_cnt_sat", {30'd0, c4}, 3);
    step("l4_sat_lu",       4, E_LU,   0, 0, 5, 5, 1, 0, 0, 0);
    for (int i = 1; i < 4; i++)
      step($sformatf("l4_sat_%0d", i), 4, E_LU, 0, 0, 0, 0, 0, 0, 0, 0);
    step("l4_sat_end",      4, E_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("l4_cnt_hold", {30'd0, c4}, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
